rf: RTL and testbench
=====================

Name: rf

Overview:
- 32-entry x 32-bit general-purpose register file for the Decode stage.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Internal write-to-read bypass, so a same-cycle read of the register being written returns the new data.
- Register 0 is an ordinary writable register; it is not hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- NUM_REGS, 32, number of registers.
- ADDR_WIDTH, 5, select width; must equal log2(NUM_REGS).

Ports:
- clk_i  input  1  clock; all register updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset; clears every register.
- read_reg1_sel_i  input  ADDR_WIDTH  read port 1 register index.
- read_reg2_sel_i  input  ADDR_WIDTH  read port 2 register index.
- write_enable_i  input  1  when high, write occurs at next rising clk_i edge.
- reg_write_dst_i  input  ADDR_WIDTH  write destination index.
- write_data_i  input  DATA_WIDTH  data to write.
- read_data1_o  output  DATA_WIDTH  contents for read_reg1_sel_i.
- read_data2_o  output  DATA_WIDTH  contents for read_reg2_sel_i.

Behaviour:
- Reset:
  - rst_i high clears all NUM_REGS registers to 0 immediately, independent of the clock.
  - Registers are held at 0 while rst_i is high.
  - Writes are ignored while rst_i is high.
  - Bypass is disabled while rst_i is high, so both outputs read 0.
- Power-up: register contents are undefined until the first reset. Benches must assert reset before checking reads.
- Write:
  - On rising clk_i, with rst_i low and write_enable_i high, mem[reg_write_dst_i] <= write_data_i.
  - Every index 0..31 is writable, including 0.
  - write_enable_i low leaves all registers unchanged, whatever reg_write_dst_i and write_data_i are.
- Read:
  - Purely combinational; zero-cycle latency from select change to output.
  - read_data1_o = mem[read_reg1_sel_i].
  - read_data2_o = mem[read_reg2_sel_i].
- Bypass:
  - Applies when write_enable_i=1, rst_i=0, and a read select equals reg_write_dst_i.
  - That port outputs write_data_i combinationally in the same cycle, before the clock edge.
  - Applies independently to each port; both ports bypass when both selects match.
- Both read ports may select the same register simultaneously, and both return identical data.
- The registered value after the edge equals the bypassed value before it, so there is no glitch in observed data across the write edge.
- No out-of-range index exists: selects are exactly ADDR_WIDTH bits wide with NUM_REGS = 2^ADDR_WIDTH.
- Reset asserted mid-cycle while a write is pending: reset wins and the write is discarded.

Test Plan:
- Reset then sweep reads:
  - Stimulus: assert rst_i, release, then set sel1=i and sel2=i+1 for i=0,2,...,30.
  - Required: both outputs read 0x00000000 for every i.
- Exhaustive write/readback:
  - Stimulus: for i=0..31, write random D_i at one edge with write_enable_i=1, then deassert write_enable_i with random dst/data and set sel1=i.
  - Required: read_data1_o==D_i, including i=0 (not hardwired).
- Same-cycle bypass:
  - Stimulus: write_enable_i=1, dst=i, data=0xDEADBEEF, sel1=i, for i=0..31.
  - Required: read_data1_o==0xDEADBEEF before the edge and after it.
- Write-enable gating:
  - Stimulus: write 0x12345678 to r7; then write_enable_i=0 with dst=7 and data=0xFFFFFFFF for several edges.
  - Required: sel2=7 reads 0x12345678.
- Dual-port independence:
  - Stimulus: 500 random writes, each to a random index, read back on a randomly chosen port while the other port holds a random select.
  - Required: the chosen port matches the scoreboard, and the other port matches its own scoreboard entry.
- Async reset mid-operation:
  - Stimulus: fill registers, pulse rst_i between clock edges while write_enable_i=1, dst=3, data=0xA5A5A5A5.
  - Required: all outputs read 0 immediately, and r3 reads 0 after reset release.

Source files
------------

// File: rtl/rf.sv
// -----------------------------------------------------------------------------
// rf -- general-purpose register file for the Decode stage.
//
// NUM_REGS x DATA_WIDTH registers with two combinational read ports and one
// synchronous write port. A read whose select matches the register being
// written in the same cycle returns the incoming write data. The registered
// value after the edge then equals the value shown before it, so readers see
// no glitch across the write edge. Register 0 is an ordinary register.
//
// Ports:
//   clk_i            clock, registers update on the rising edge
//   rst_i            asynchronous active-high reset, clears every register
//   read_reg1_sel_i  read port 1 register index
//   read_reg2_sel_i  read port 2 register index
//   write_enable_i   write reg_write_dst_i at the next rising edge when high
//   reg_write_dst_i  write destination index
//   write_data_i     write data
//   read_data1_o     contents of read_reg1_sel_i (bypassed)
//   read_data2_o     contents of read_reg2_sel_i (bypassed)
//
// ADDR_WIDTH must equal log2(NUM_REGS). Every select value then names a real
// register, so the read and write paths need no range check.
// -----------------------------------------------------------------------------
module rf #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] read_reg1_sel_i,
    input  logic [ADDR_WIDTH-1:0] read_reg2_sel_i,
    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] reg_write_dst_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic [DATA_WIDTH-1:0] read_data1_o,
    output logic [DATA_WIDTH-1:0] read_data2_o
);

    // The asynchronous clear of every entry forces the storage into flops.
    // It cannot map to block RAM.
    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

    // Both read ports share one select/data layout so a single generate loop
    // can build them.
    logic [ADDR_WIDTH-1:0] rd_sel [2];

    assign rd_sel[0] = read_reg1_sel_i;
    assign rd_sel[1] = read_reg2_sel_i;

    // Next-state: only the addressed entry takes the write data.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
            if (write_enable_i && (reg_write_dst_i == ADDR_WIDTH'(i))) begin
                mem_d[i] = write_data_i;
            end
        end
    end

    // Reset dominates any pending write. Writes are lost while rst_i is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read ports. The bypass is gated by rst_i. During reset the array is
    // already zero, so both ports read zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] data;
            logic                  bypass;

            always_comb begin
                bypass = !rst_i && write_enable_i && (rd_sel[gi] == reg_write_dst_i);
                data   = bypass ? write_data_i : mem_q[rd_sel[gi]];
            end
        end
    endgenerate

    assign read_data1_o = g_rd[0].data;
    assign read_data2_o = g_rd[1].data;

endmodule

// File: tb/tb_rf.sv
// -----------------------------------------------------------------------------
// tb_rf -- self-checking bench for rf.
//
// The bench uses directed sequences with expected values worked out in the
// bench. It also keeps a small scoreboard of register contents for the random
// write/readback phase. Inputs change 1 ns after a rising edge, and outputs are
// sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_rf;

    logic        clk;
    logic        rst;
    logic [4:0]  sel1;
    logic [4:0]  sel2;
    logic        we;
    logic [4:0]  dst;
    logic [31:0] wdata;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] sb [32];

    rf dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .read_reg1_sel_i (sel1),
        .read_reg2_sel_i (sel2),
        .write_enable_i  (we),
        .reg_write_dst_i (dst),
        .write_data_i    (wdata),
        .read_data1_o    (rd1),
        .read_data2_o    (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write one register over one edge, then drop the enable and scramble
    // dst/data. This shows that a disabled write port has no effect.
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] d);
        we    = 1'b1;
        dst   = idx;
        wdata = d;
        tick();
        sb[idx] = d;
        $display("wr r%0d <= %h", idx, d);
        we    = 1'b0;
        dst   = 5'($urandom);
        wdata = $urandom;
    endtask

    initial begin
        logic [4:0]  idx;
        logic [4:0]  other;
        logic [31:0] d;
        int          port;

        rst   = 1'b0;
        we    = 1'b0;
        dst   = '0;
        wdata = '0;
        sel1  = '0;
        sel2  = '0;

        // Reset, then sweep reads.
        #2 rst = 1'b1;
        #1 check_val("rd1 during reset", rd1, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            sel1 = 5'(i);
            sel2 = 5'(i + 1);
            #1;
            $display("rd r%0d/r%0d after reset", i, i + 1);
            check_val($sformatf("reset rd1 r%0d", i), rd1, 32'h0);
            check_val($sformatf("reset rd2 r%0d", i + 1), rd2, 32'h0);
        end
        for (int i = 0; i < 32; i++) sb[i] = 32'h0;

        // Exhaustive write and readback, including r0.
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            write_reg(5'(i), d);
            sel1 = 5'(i);
            #1;
            check_val($sformatf("wr/rd r%0d", i), rd1, d);
        end

        // Same-cycle bypass, both before and after the edge.
        for (int i = 0; i < 32; i++) begin
            we    = 1'b1;
            dst   = 5'(i);
            wdata = 32'hDEADBEEF;
            sel1  = 5'(i);
            #1;
            check_val($sformatf("bypass pre r%0d", i), rd1, 32'hDEADBEEF);
            tick();
            sb[i] = 32'hDEADBEEF;
            we    = 1'b0;
            wdata = 32'h0;
            #1;
            $display("bypass r%0d", i);
            check_val($sformatf("bypass post r%0d", i), rd1, 32'hDEADBEEF);
        end

        // Write-enable gating. r7 must hold across disabled write attempts.
        write_reg(5'd7, 32'h12345678);
        sel2 = 5'd7;
        for (int k = 0; k < 4; k++) begin
            we    = 1'b0;
            dst   = 5'd7;
            wdata = 32'hFFFFFFFF;
            #1;
            check_val($sformatf("gate pre %0d", k), rd2, 32'h12345678);
            tick();
            $display("gated edge %0d", k);
            check_val($sformatf("gate post %0d", k), rd2, 32'h12345678);
        end

        // Dual-port independence: random writes checked against the scoreboard.
        for (int n = 0; n < 500; n++) begin
            idx   = 5'($urandom_range(0, 31));
            d     = $urandom;
            write_reg(idx, d);
            other = 5'($urandom_range(0, 31));
            port  = $urandom_range(0, 1);
            if (port == 0) begin
                sel1 = idx;
                sel2 = other;
            end else begin
                sel1 = other;
                sel2 = idx;
            end
            #1;
            check_val($sformatf("rand%0d rd1 r%0d", n, sel1), rd1, sb[sel1]);
            check_val($sformatf("rand%0d rd2 r%0d", n, sel2), rd2, sb[sel2]);
        end

        // Both ports select the same register.
        sel1 = 5'd9;
        sel2 = 5'd9;
        #1;
        check_val("same sel rd1", rd1, sb[9]);
        check_val("same sel rd2", rd2, sb[9]);

        // Both ports bypass together.
        we    = 1'b1;
        dst   = 5'd9;
        wdata = 32'hCAFEF00D;
        #1;
        check_val("dual bypass rd1", rd1, 32'hCAFEF00D);
        check_val("dual bypass rd2", rd2, 32'hCAFEF00D);
        tick();
        sb[9] = 32'hCAFEF00D;
        $display("wr r9 <= cafef00d (dual bypass)");

        // Async reset mid-cycle with a write to r3 pending.
        write_reg(5'd3, 32'h11112222);
        we    = 1'b1;
        dst   = 5'd3;
        wdata = 32'hA5A5A5A5;
        sel1  = 5'd3;
        sel2  = 5'd5;
        #1;
        check_val("pre-reset bypass r3", rd1, 32'hA5A5A5A5);
        #1 rst = 1'b1;
        #1;
        $display("async reset asserted mid-cycle");
        check_val("reset now rd1", rd1, 32'h0);
        check_val("reset now rd2", rd2, 32'h0);
        tick();
        check_val("reset edge rd1", rd1, 32'h0);
        #2;
        we  = 1'b0;
        rst = 1'b0;
        #1;
        check_val("post reset r3", rd1, 32'h0);
        for (int i = 0; i < 32; i++) begin
            sel2 = 5'(i);
            #1;
            check_val($sformatf("post reset r%0d", i), rd2, 32'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
